// File: rtl/rv_shift_seq.sv
// Sequential barrel-shift replacement: performs an N-bit shift as N single-bit
// steps through one rv_shifter, with start/busy/done handshake and flush.

module rv_shifter #(
   parameter int DW = 32
) (
   input  logic [1:0]    op,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);
   genvar gi;
   generate
      for (gi = 0; gi < DW; gi++) begin : g_bit
         logic lbit;
         logic rbit;
         if (gi == 0) begin : g_lsb
            assign lbit = 1'b0;
         end else begin : g_lmid
            assign lbit = din[gi-1];
         end
         // op[0] distinguishes arithmetic (sign fill) from logical right shift
         if (gi == DW - 1) begin : g_msb
            assign rbit = op[0] & din[DW-1];
         end else begin : g_rmid
            assign rbit = din[gi+1];
         end
         assign dout[gi] = (op == 2'b01) ? lbit :
                           op[1]         ? rbit : din[gi];
      end
   endgenerate
endmodule

module rv_shift_seq #(
   parameter int DW = 32,
   parameter int SW = $clog2(DW)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [DW-1:0] operand,
   input  logic [SW-1:0] shamt,
   input  logic          flush,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] result
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        state_reg, state_next;
   logic [SW-1:0] cnt_reg, cnt_next;
   logic [DW-1:0] work_reg, work_next;
   logic [1:0]    op_reg, op_next;
   logic [DW-1:0] shift_out;
   logic [SW-1:0] load_cnt;

   // op_reg is never 00 while in SHIFT because a pass op loads a zero count
   rv_shifter #(.DW(DW)) u_shifter (
      .op   (op_reg),
      .din  (work_reg),
      .dout (shift_out)
   );

   assign load_cnt = (op == 2'b00) ? '0 : shamt;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      work_next  = work_reg;
      op_next    = op_reg;
      case (state_reg)
         IDLE: begin
            if (start && !flush) begin
               work_next  = operand;
               op_next    = op;
               cnt_next   = load_cnt;
               state_next = (load_cnt != '0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (flush) begin
               state_next = IDLE;
            end else begin
               work_next = shift_out;
               cnt_next  = cnt_reg - SW'(1);
               if (cnt_reg == SW'(1))
                  state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         work_reg  <= '0;
         op_reg    <= 2'b00;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         work_reg  <= work_next;
         op_reg    <= op_next;
      end
   end

   assign busy   = (state_reg != IDLE);
   assign done   = (state_reg == DONE);
   assign result = work_reg;
endmodule

// File: tb/tb_rv_shift_seq.sv
// Directed bench for rv_shift_seq: latency, fill rules, ignored starts, flush
// and asynchronous reset, with hand-computed expected values.

module tb_rv_shift_seq;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] operand;
   logic [4:0]  shamt;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   rv_shift_seq #(.DW(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .operand (operand),
      .shamt   (shamt),
      .flush   (flush),
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; op = 2'b01; operand = 32'hFFFF_FFFF; shamt = 5'd3; flush = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
         bad++;
         $display("FAIL reset_state busy=%b done=%b result=%h required 0/0/00000000", busy, done, result);
      end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle busy=%b required 0", busy);
      end
   endtask

   // op=01 0x1 << 31: busy cycles 1..32, done only in cycle 32
   task automatic test_sll31();
      int done_cnt = 0, done_at = -1;
      bit busy_ok = 1;
      start = 1'b1; op = 2'b01; operand = 32'h1; shamt = 5'd31;
      for (int c = 1; c <= 34; c++) begin
         @(negedge clk); start = 1'b0;
         if (done === 1'b1) begin done_cnt++; done_at = c; end
         if (busy !== (c <= 32)) busy_ok = 0;
      end
      total++;
      if (done_at != 32 || done_cnt != 1) begin
         bad++;
         $display("FAIL sll31_done at=%0d count=%0d required at=32 count=1", done_at, done_cnt);
      end
      total++;
      if (!busy_ok) begin
         bad++;
         $display("FAIL sll31_busy busy window wrong, required cycles 1..32");
      end
      total++;
      if (result !== 32'h8000_0000) begin
         bad++;
         $display("FAIL sll31_result got=%h required 80000000", result);
      end
   endtask

   // Table of single ops: done must land in cycle N+1 with the listed result
   task automatic test_table();
      logic [1:0]  t_op  [8] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b11, 2'b01};
      logic [31:0] t_opd [8] = '{32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'h1357_2468,
                                 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'hA5A5_A5A5};
      logic [4:0]  t_sh  [8] = '{5'd4, 5'd4, 5'd0, 5'd7, 5'd31, 5'd31, 5'd31, 5'd16};
      logic [31:0] t_exp [8] = '{32'hF800_0000, 32'h0800_0000, 32'hDEAD_BEEF, 32'h1357_2468,
                                 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hA5A5_0000};
      int t_lat [8] = '{5, 5, 1, 1, 32, 32, 32, 17};
      for (int i = 0; i < 8; i++) begin
         int done_at = -1, done_cnt = 0;
         start = 1'b1; op = t_op[i]; operand = t_opd[i]; shamt = t_sh[i];
         for (int c = 1; c <= t_lat[i] + 1; c++) begin
            @(negedge clk); start = 1'b0;
            if (done === 1'b1) begin done_cnt++; done_at = c; end
         end
         total++;
         if (done_at != t_lat[i] || done_cnt != 1 || result !== t_exp[i]) begin
            bad++;
            $display("FAIL table_%0d done_at=%0d count=%0d result=%h required done_at=%0d count=1 result=%h",
                     i, done_at, done_cnt, result, t_lat[i], t_exp[i]);
         end
      end
   endtask

   // Starts in cycles 2 and 9 (busy / DONE) must be ignored
   task automatic test_ignored_start();
      int done_at = -1, done_cnt = 0;
      start = 1'b1; op = 2'b10; operand = 32'hFFFF_FFFF; shamt = 5'd8;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin done_cnt++; done_at = c; end
         if (c == 10) begin
            total++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL ignored_start_busy10 busy=%b required 0", busy);
            end
         end
         start = (c == 2 || c == 9);
         operand = 32'h1234_5678; shamt = 5'd1; op = 2'b01;
      end
      start = 1'b0;
      total++;
      if (done_at != 9 || done_cnt != 1) begin
         bad++;
         $display("FAIL ignored_start_done at=%0d count=%0d required at=9 count=1", done_at, done_cnt);
      end
      total++;
      if (result !== 32'h00FF_FFFF) begin
         bad++;
         $display("FAIL ignored_start_result got=%h required 00ffffff", result);
      end
   endtask

   // Flush in cycle 4 of a 10-step SLL leaves three shifts applied
   task automatic test_flush();
      int done_cnt = 0;
      bit busy_ok = 1;
      start = 1'b1; op = 2'b01; operand = 32'h1; shamt = 5'd10;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk); start = 1'b0;
         if (done === 1'b1) done_cnt++;
         if (busy !== (c <= 4)) busy_ok = 0;
         flush = (c == 4);
      end
      total++;
      if (done_cnt != 0 || !busy_ok) begin
         bad++;
         $display("FAIL flush_ctrl done_count=%0d busy_ok=%0d required 0 and 1", done_cnt, busy_ok);
      end
      total++;
      if (result !== 32'h0000_0008) begin
         bad++;
         $display("FAIL flush_result got=%h required 00000008", result);
      end
      // flush beats a simultaneous start in IDLE
      start = 1'b1; flush = 1'b1; op = 2'b10; operand = 32'hFFFF_0000; shamt = 5'd2;
      @(negedge clk); start = 1'b0; flush = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0000_0008) begin
         bad++;
         $display("FAIL flush_idle busy=%b done=%b result=%h required 0/0/00000008", busy, done, result);
      end
   endtask

   // Async reset mid-SRA, then a fresh op right after release
   task automatic test_reset_mid();
      int done_at = -1, done_cnt = 0;
      start = 1'b1; op = 2'b11; operand = 32'h8000_0000; shamt = 5'd20;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk); start = 1'b0;
      end
      rst = 1'b1;
      #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
         bad++;
         $display("FAIL reset_mid busy=%b done=%b result=%h required 0/0/00000000", busy, done, result);
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b1; op = 2'b01; operand = 32'h1; shamt = 5'd1;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk); start = 1'b0;
         if (done === 1'b1) begin done_cnt++; done_at = c; end
      end
      total++;
      if (done_at != 2 || done_cnt != 1 || result !== 32'h2) begin
         bad++;
         $display("FAIL reset_recover done_at=%0d count=%0d result=%h required 2/1/00000002",
                  done_at, done_cnt, result);
      end
   endtask

   initial begin
      test_reset();
      test_sll31();
      test_table();
      test_ignored_start();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
